// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// Receive end of the XOR-parity serial link. Bits arrive one per bit_valid
// strobe and are deframed as start / DATA_W data bits (LSB first) / parity /
// stop. Parity is recomputed on the fly and compared against the received
// parity bit. A frame that stalls for TIMEOUT cycles between strobes is
// abandoned and reported as a framing error.
module parity_frame_checker #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int TIMEOUT    = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              frame_done,
    output logic              parity_err,
    output logic              framing_err,
    output logic              busy,
    output logic              LED
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    // Value of the bit counter while the last data bit is being received.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // The timeout fires on the TIMEOUT-th consecutive cycle without a strobe.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    localparam logic ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              acc;
    logic              perr;
    logic              timeout_hit;

    // Next shift-register value: new bit enters at the MSB so that after
    // DATA_W LSB-first bits the register holds the word in natural order.
    always_comb begin
        shift_next             = shift_reg >> 1;
        shift_next[DATA_W-1]   = bit_in;
    end

    // A strobe in the same cycle always beats the timeout.
    assign timeout_hit = (state != IDLE) && !bit_valid && (tmo_cnt == TMO_LAST);

    // Deframing state machine with the registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            acc         <= 1'b0;
            perr        <= 1'b0;
            data_out    <= '0;
            frame_done  <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (state == IDLE || bit_valid) begin
                tmo_cnt <= '0;
            end else if (!timeout_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bit_valid && !bit_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        acc     <= 1'b0;
                    end
                end

                DATA: begin
                    if (bit_valid) begin
                        shift_reg <= shift_next;
                        acc       <= acc ^ bit_in;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (bit_valid) begin
                        perr  <= acc ^ bit_in ^ ODD_BIT;
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (bit_valid) begin
                        data_out    <= shift_reg;
                        parity_err  <= perr;
                        framing_err <= !bit_in;
                        frame_done  <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (timeout_hit) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                tmo_cnt     <= '0;
                framing_err <= 1'b1;
                parity_err  <= 1'b0;
                frame_done  <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);
    assign LED  = parity_err | framing_err;

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker
// Directed bench for parity_frame_checker. Two instances share the serial
// input: one configured for even parity, one for odd parity. Inputs change on
// the falling edge and outputs are sampled on the falling edge.
module tb_parity_frame_checker;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 20;

    logic              clk       = 1'b0;
    logic              rst_n     = 1'b0;
    logic              bit_valid = 1'b0;
    logic              bit_in    = 1'b1;

    logic [DATA_W-1:0] data_out_e;
    logic              frame_done_e;
    logic              parity_err_e;
    logic              framing_err_e;
    logic              busy_e;
    logic              LED_e;

    logic [DATA_W-1:0] data_out_o;
    logic              frame_done_o;
    logic              parity_err_o;
    logic              framing_err_o;
    logic              busy_o;
    logic              LED_o;

    int test_count = 0;
    int fail_count = 0;
    int done_cnt_e = 0;
    int done_cnt_o = 0;
    logic prev_done_e = 1'b0;
    logic prev_done_o = 1'b0;

    parity_frame_checker #(
        .DATA_W    (DATA_W),
        .PARITY_ODD(0),
        .TIMEOUT   (TIMEOUT)
    ) dut_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_out   (data_out_e),
        .frame_done (frame_done_e),
        .parity_err (parity_err_e),
        .framing_err(framing_err_e),
        .busy       (busy_e),
        .LED        (LED_e)
    );

    parity_frame_checker #(
        .DATA_W    (DATA_W),
        .PARITY_ODD(1),
        .TIMEOUT   (TIMEOUT)
    ) dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_out   (data_out_o),
        .frame_done (frame_done_o),
        .parity_err (parity_err_o),
        .framing_err(framing_err_o),
        .busy       (busy_o),
        .LED        (LED_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case something wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Count completion pulses and catch any pulse longer than one cycle.
    always @(posedge clk) begin
        if (frame_done_e) done_cnt_e++;
        if (frame_done_o) done_cnt_o++;
        if (frame_done_e && prev_done_e) checkOutput("even_done_twice", 1, 0);
        if (frame_done_o && prev_done_o) checkOutput("odd_done_twice", 1, 0);
        prev_done_e = frame_done_e;
        prev_done_o = frame_done_o;
    end

    // One strobed bit; called and returns on a falling edge.
    task automatic applyStimulus(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Non-strobed cycles with a toggling line that must be ignored.
    task automatic idleNoise(input int n);
        repeat (n) begin
            bit_in = ~bit_in;
            @(negedge clk);
        end
    endtask

    // Full frame; returns on the falling edge right after the stop strobe.
    task automatic sendFrame(input logic [7:0] d, input logic p, input logic s, input int gap);
        applyStimulus(1'b0);
        if (gap > 0) idleNoise(gap);
        for (int i = 0; i < DATA_W; i++) begin
            applyStimulus(d[i]);
            if (gap > 0) idleNoise(gap);
        end
        applyStimulus(p);
        if (gap > 0) idleNoise(gap);
        applyStimulus(s);
    endtask

    task automatic checkEven(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        checkOutput({tag, "_even_data"}, 32'(data_out_e), 32'(d));
        checkOutput({tag, "_even_perr"}, 32'(parity_err_e), 32'(pe));
        checkOutput({tag, "_even_ferr"}, 32'(framing_err_e), 32'(fe));
        checkOutput({tag, "_even_led"}, 32'(LED_e), 32'(pe | fe));
        checkOutput({tag, "_even_busy"}, 32'(busy_e), 0);
    endtask

    task automatic checkOdd(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        checkOutput({tag, "_odd_data"}, 32'(data_out_o), 32'(d));
        checkOutput({tag, "_odd_perr"}, 32'(parity_err_o), 32'(pe));
        checkOutput({tag, "_odd_ferr"}, 32'(framing_err_o), 32'(fe));
        checkOutput({tag, "_odd_led"}, 32'(LED_o), 32'(pe | fe));
        checkOutput({tag, "_odd_busy"}, 32'(busy_o), 0);
    endtask

    // Directed sequence.
    initial begin
        int base_e;
        int base_o;
        int waited;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkEven("reset", 8'h00, 1'b0, 1'b0);
        checkOdd("reset", 8'h00, 1'b0, 1'b0);
        checkOutput("reset_done", 32'(frame_done_e), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle-level strobes must not start a frame.
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        checkOutput("idle_ones_busy", 32'(busy_e), 0);

        // Good even-parity frame 0xA5.
        base_e = done_cnt_e;
        sendFrame(8'hA5, 1'b0, 1'b1, 0);
        checkOutput("t1_pulse", 32'(frame_done_e), 1);
        checkOutput("t1_busy_falls", 32'(busy_e), 0);
        @(negedge clk);
        checkOutput("t1_pulse_width", 32'(frame_done_e), 0);
        checkEven("t1", 8'hA5, 1'b0, 1'b0);
        checkOutput("t1_count", 32'(done_cnt_e - base_e), 1);

        // Wrong parity bit.
        sendFrame(8'hA5, 1'b1, 1'b1, 0);
        @(negedge clk);
        checkEven("t2", 8'hA5, 1'b1, 1'b0);

        // Bad stop bit, with ignored noise between strobes.
        sendFrame(8'h3C, 1'b0, 1'b0, 3);
        @(negedge clk);
        checkEven("t3", 8'h3C, 1'b0, 1'b1);

        // Every strobe arrives on the very cycle the timeout would fire.
        sendFrame(8'hC3, 1'b0, 1'b1, TIMEOUT - 1);
        @(negedge clk);
        checkEven("t_gap", 8'hC3, 1'b0, 1'b0);

        // Stall after three data bits.
        applyStimulus(1'b0);
        checkOutput("t4_busy_mid", 32'(busy_e), 1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        waited = 0;
        for (int k = 1; k <= 4 * TIMEOUT; k++) begin
            @(negedge clk);
            if (frame_done_e) begin
                waited = k;
                break;
            end
        end
        checkOutput("t4_timeout_cycles", 32'(waited), 32'(TIMEOUT));
        checkEven("t4", 8'hC3, 1'b0, 1'b1);
        @(negedge clk);

        // Odd parity, two frames back to back.
        base_o = done_cnt_o;
        sendFrame(8'h01, 1'b0, 1'b1, 0);
        checkOutput("t5_f1_odd_data", 32'(data_out_o), 32'h01);
        checkOutput("t5_f1_odd_perr", 32'(parity_err_o), 0);
        checkOutput("t5_f1_even_perr", 32'(parity_err_e), 1);
        sendFrame(8'h03, 1'b1, 1'b1, 0);
        @(negedge clk);
        checkOdd("t5_f2", 8'h03, 1'b0, 1'b0);
        checkOutput("t5_count", 32'(done_cnt_o - base_o), 2);

        // Reset in the middle of a frame.
        base_e = done_cnt_e;
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        checkEven("t6_reset", 8'h00, 1'b0, 1'b0);
        checkOutput("t6_reset_done", 32'(frame_done_e), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t6_no_done", 32'(done_cnt_e - base_e), 0);
        sendFrame(8'h5A, 1'b0, 1'b1, 0);
        @(negedge clk);
        checkEven("t6_after", 8'h5A, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
